// File: rtl/user2bft_packetizer.sv
// user2bft_packetizer: wraps user ap_vld/ap_ack payloads into BFT
// packets, metered by credits for the receiver's input buffer.
module user2bft_packetizer #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int IN_FIFO_DEPTH         = 2
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     cfg_wr,
  input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
  input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
  input  logic [PAYLOAD_BITS-1:0]  din,
  input  logic                     din_ap_vld,
  output logic                     din_ap_ack,
  output logic [PACKET_BITS-1:0]   pkt_out,
  output logic                     pkt_vld,
  input  logic                     pkt_rdy,
  input  logic                     credit_return,
  output logic                     configured,
  output logic [NUM_ADDR_BITS:0]   credits,
  output logic                     err_credit_ovf
);

  localparam int CRED_BITS = NUM_ADDR_BITS + 1;
  localparam int PTR_BITS  = $clog2(IN_FIFO_DEPTH);
  localparam int CNT_BITS  = PTR_BITS + 1;

  localparam logic [CRED_BITS:0] CRED_MAX =
    (CRED_BITS+1)'(1) << NUM_ADDR_BITS;
  localparam logic [CRED_BITS:0] CRED_RET =
    (CRED_BITS+1)'(FREESPACE_UPDATE_SIZE);
  localparam logic [CNT_BITS-1:0] FULL =
    CNT_BITS'(IN_FIFO_DEPTH);

  typedef enum logic {
    UNCFG,
    RUN
  } state_t;

  state_t state;

  logic [NUM_LEAF_BITS-1:0] dest_leaf;
  logic [NUM_PORT_BITS-1:0] dest_port;

  logic [PAYLOAD_BITS-1:0] mem [IN_FIFO_DEPTH];
  logic [PTR_BITS-1:0]     wr_ptr;
  logic [PTR_BITS-1:0]     rd_ptr;
  logic [CNT_BITS-1:0]     count;
  logic [CNT_BITS-1:0]     count_nxt;

  logic [NUM_ADDR_BITS-1:0] addr;
  logic [CRED_BITS:0]       cred_sum;

  logic push;
  logic load;

  // Handshake qualifiers, next FIFO occupancy and unsaturated credits
  always_comb begin
    push = din_ap_vld && din_ap_ack;
    load = (count != '0) && (credits != '0) &&
           (!pkt_vld || pkt_rdy);
    count_nxt = count + CNT_BITS'(push) - CNT_BITS'(load);
    cred_sum = {1'b0, credits} - (CRED_BITS+1)'(load);
    if (credit_return)
      cred_sum = cred_sum + CRED_RET;
  end

  // Control FSM: configuration latch and registered input ack
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state      <= UNCFG;
      configured <= 1'b0;
      din_ap_ack <= 1'b0;
      dest_leaf  <= '0;
      dest_port  <= '0;
    end else begin
      if (cfg_wr) begin
        dest_leaf <= cfg_dest_leaf;
        dest_port <= cfg_dest_port;
      end
      unique case (state)
        UNCFG: begin
          if (cfg_wr) begin
            state      <= RUN;
            configured <= 1'b1;
            din_ap_ack <= (count_nxt != FULL);
          end else begin
            din_ap_ack <= 1'b0;
          end
        end
        RUN: begin
          din_ap_ack <= (count_nxt != FULL);
        end
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge ap_clk) begin
    if (push)
      mem[wr_ptr] <= din;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (load)
        rd_ptr <= rd_ptr + PTR_BITS'(1);
      count <= count_nxt;
    end
  end

  // Output register: load a new packet or clear after handoff
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pkt_out <= '0;
      pkt_vld <= 1'b0;
    end else if (load) begin
      pkt_out <= {1'b1, dest_leaf, dest_port, addr,
                  mem[rd_ptr]};
      pkt_vld <= 1'b1;
    end else if (pkt_vld && pkt_rdy) begin
      pkt_out <= '0;
      pkt_vld <= 1'b0;
    end
  end

  // Receiver address and saturating credit counter
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      addr           <= '0;
      credits        <= CRED_MAX[CRED_BITS-1:0];
      err_credit_ovf <= 1'b0;
    end else begin
      if (load)
        addr <= addr + NUM_ADDR_BITS'(1);
      if (cred_sum > CRED_MAX) begin
        credits        <= CRED_MAX[CRED_BITS-1:0];
        err_credit_ovf <= 1'b1;
      end else begin
        credits <= cred_sum[CRED_BITS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_user2bft_packetizer.sv
// tb_user2bft_packetizer: vector table, directed corner cases and a
// randomized run against a transaction-level packet/credit model.
module tb_user2bft_packetizer;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [4:0]  cfg_dest_leaf = '0;
  logic [3:0]  cfg_dest_port = '0;
  logic [31:0] din = '0;
  logic        din_ap_vld = 1'b0;
  logic        din_ap_ack;
  logic [48:0] pkt_out;
  logic        pkt_vld;
  logic        pkt_rdy = 1'b0;
  logic        credit_return = 1'b0;
  logic        configured;
  logic [7:0]  credits;
  logic        err_credit_ovf;

  user2bft_packetizer dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .cfg_wr         (cfg_wr),
    .cfg_dest_leaf  (cfg_dest_leaf),
    .cfg_dest_port  (cfg_dest_port),
    .din            (din),
    .din_ap_vld     (din_ap_vld),
    .din_ap_ack     (din_ap_ack),
    .pkt_out        (pkt_out),
    .pkt_vld        (pkt_vld),
    .pkt_rdy        (pkt_rdy),
    .credit_return  (credit_return),
    .configured     (configured),
    .credits        (credits),
    .err_credit_ovf (err_credit_ovf)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [4:0]  leaf;
    logic [3:0]  port;
    logic [31:0] data;
    logic [48:0] pkt;
  } vec_t;

  vec_t vecs[4];

  int checks = 0;
  int errors = 0;

  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];
  logic [48:0] got_q[$];

  int cyc = 0;
  int acc_cnt = 0;
  int dlv_cnt = 0;
  int acc_cyc = 0;

  bit          gate = 1'b1;
  bit          hold_chk = 1'b0;
  logic [48:0] prev_pkt = '0;

  logic [4:0] m_leaf = '0;
  logic [3:0] m_port = '0;
  logic [6:0] m_addr = '0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    end
  endtask

  function automatic logic [7:0] got_addr(input int i);
    logic [48:0] p;
    if (i >= got_q.size()) return 8'hFF;
    p = got_q[i];
    return {1'b0, p[38:32]};
  endfunction

  function automatic logic [7:0] got_leaf(input int i);
    logic [48:0] p;
    if (i >= got_q.size()) return 8'hFF;
    p = got_q[i];
    return {3'b0, p[47:43]};
  endfunction

  // One clock cycle: present inputs, score both handshakes, advance
  task automatic tick();
    logic [48:0] e;
    din_ap_vld = gate && (src_q.size() > 0);
    din = (src_q.size() > 0) ? src_q[0] : 32'h0;
    if (hold_chk)
      chk("hold", {pkt_vld, pkt_out}, {1'b1, prev_pkt});
    if (!pkt_vld)
      chk("idle_zero", pkt_out, 0);
    hold_chk = pkt_vld && !pkt_rdy;
    prev_pkt = pkt_out;
    if (din_ap_vld && din_ap_ack) begin
      exp_q.push_back(src_q.pop_front());
      acc_cnt++;
      acc_cyc = cyc;
    end
    if (pkt_vld && pkt_rdy) begin
      got_q.push_back(pkt_out);
      dlv_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious: got 0x%0h expected none",
                 pkt_out);
      end else begin
        e = {1'b1, m_leaf, m_port, m_addr, exp_q.pop_front()};
        chk("pkt", pkt_out, e);
        m_addr++;
      end
    end
    @(negedge ap_clk);
    cyc++;
    cfg_wr = 1'b0;
    credit_return = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic cfg(input logic [4:0] l, input logic [3:0] p);
    cfg_wr = 1'b1;
    cfg_dest_leaf = l;
    cfg_dest_port = p;
    tick();
    m_leaf = l;
    m_port = p;
  endtask

  task automatic clear_model();
    src_q.delete();
    exp_q.delete();
    got_q.delete();
    acc_cnt = 0;
    dlv_cnt = 0;
    m_addr = '0;
    hold_chk = 1'b0;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    din_ap_vld = 1'b0;
    cfg_wr = 1'b0;
    credit_return = 1'b0;
    pkt_rdy = 1'b0;
    gate = 1'b1;
    clear_model();
    m_leaf = '0;
    m_port = '0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++)
      src_q.push_back($urandom);
  endtask

  initial begin
    int t0;
    int n0;
    int nret;
    bit seen;

    vecs[0] = '{5'd5,  4'd3,  32'hDEADBEEF, 49'h1_2980_DEADBEEF};
    vecs[1] = '{5'd31, 4'd15, 32'hFFFFFFFF, 49'h1_FF80_FFFFFFFF};
    vecs[2] = '{5'd0,  4'd0,  32'h00000000, 49'h1_0000_00000000};
    vecs[3] = '{5'd16, 4'd1,  32'h12345678, 49'h1_8080_12345678};

    // Reset state
    do_reset();
    chk("rst_ack", din_ap_ack, 0);
    chk("rst_vld", pkt_vld, 0);
    chk("rst_pkt", pkt_out, 0);
    chk("rst_cfg", configured, 0);
    chk("rst_err", err_credit_ovf, 0);
    chk("rst_cred", credits, 128);

    // Packet format and latency vectors
    foreach (vecs[i]) begin
      do_reset();
      cfg(vecs[i].leaf, vecs[i].port);
      pkt_rdy = 1'b0;
      src_q.push_back(vecs[i].data);
      t0 = -1;
      for (int k = 0; k < 10 && t0 < 0; k++) begin
        tick();
        if (pkt_vld) t0 = cyc;
      end
      chk("vec_lat", t0 - acc_cyc, 2);
      chk("vec_pkt", pkt_out, vecs[i].pkt);
      chk("vec_cred", credits, 127);
      pkt_rdy = 1'b1;
      run(2);
      chk("vec_dlv", dlv_cnt, 1);
    end

    // Unconfigured: no ack, no packets, then first word accepted
    do_reset();
    pkt_rdy = 1'b1;
    src_q.push_back(32'hA5A50001);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (din_ap_ack || pkt_vld) seen = 1'b1;
    end
    chk("uncfg_quiet", seen, 0);
    chk("uncfg_acc", acc_cnt, 0);
    chk("uncfg_flag", configured, 0);
    cfg(5'd5, 4'd3);
    chk("cfg_flag", configured, 1);
    run(6);
    chk("first_acc", acc_cnt, 1);
    chk("first_dlv", dlv_cnt, 1);

    // Credit exhaustion, address wrap, mid-stream leaf change
    do_reset();
    cfg(5'd5, 4'd3);
    pkt_rdy = 1'b1;
    push_rand(130);
    run(150);
    chk("str_dlv", dlv_cnt, 128);
    chk("str_acc", acc_cnt, 130);
    chk("str_cred", credits, 0);
    chk("str_ack", din_ap_ack, 0);
    chk("str_vld", pkt_vld, 0);
    chk("str_last_addr", got_addr(127), 127);
    credit_return = 1'b1;
    run(10);
    chk("ret_dlv", dlv_cnt, 130);
    chk("ret_addr", got_addr(128), 0);
    chk("ret_cred", credits, 62);
    cfg(5'd7, 4'd3);
    push_rand(3);
    run(10);
    chk("l7_dlv", dlv_cnt, 133);
    chk("l7_leaf", got_leaf(132), 7);
    chk("l7_addr", got_addr(132), 4);
    chk("l7_cred", credits, 59);

    // Backpressure: hold pkt_rdy low with a packet pending
    pkt_rdy = 1'b0;
    n0 = acc_cnt;
    push_rand(5);
    run(10);
    chk("bp_acc", acc_cnt - n0, 3);
    chk("bp_vld", pkt_vld, 1);
    chk("bp_ack", din_ap_ack, 0);
    chk("bp_cred", credits, 58);
    pkt_rdy = 1'b1;
    run(15);
    chk("bp_dlv", dlv_cnt, 138);
    chk("bp_left", exp_q.size(), 0);
    chk("bp_cred2", credits, 54);

    // Credit overflow and return coinciding with a load
    do_reset();
    cfg(5'd1, 4'd2);
    pkt_rdy = 1'b1;
    push_rand(28);
    run(40);
    chk("c100", credits, 100);
    chk("c100_err", err_credit_ovf, 0);
    credit_return = 1'b1;
    tick();
    chk("ovf_cred", credits, 128);
    chk("ovf_err", err_credit_ovf, 1);
    push_rand(118);
    run(140);
    chk("c10", credits, 10);
    chk("ovf_sticky", err_credit_ovf, 1);
    src_q.push_back(32'h00001234);
    tick();
    chk("c10_acc", acc_cnt, 147);
    credit_return = 1'b1;
    tick();
    chk("c73", credits, 73);
    run(3);
    chk("c73_dlv", dlv_cnt, 147);

    // Asynchronous reset with FIFO full and a packet pending
    do_reset();
    cfg(5'd9, 4'd9);
    pkt_rdy = 1'b0;
    push_rand(5);
    run(8);
    chk("pre_vld", pkt_vld, 1);
    chk("pre_ack", din_ap_ack, 0);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("ar_vld", pkt_vld, 0);
    chk("ar_ack", din_ap_ack, 0);
    chk("ar_pkt", pkt_out, 0);
    din_ap_vld = 1'b0;
    clear_model();
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    chk("ar_cred", credits, 128);
    chk("ar_cfg", configured, 0);
    cfg(5'd9, 4'd9);
    pkt_rdy = 1'b1;
    push_rand(1);
    run(6);
    chk("ar_dlv", dlv_cnt, 1);
    chk("ar_addr", got_addr(0), 0);

    // Randomized traffic against the packet/credit model
    do_reset();
    cfg(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)));
    nret = 0;
    for (int c = 0; c < 3000; c++) begin
      gate = ($urandom_range(0, 3) != 0);
      pkt_rdy = ($urandom_range(0, 3) != 0);
      if (src_q.size() < 4 && $urandom_range(0, 1) == 1)
        src_q.push_back($urandom);
      if (dlv_cnt >= 64 + 64 * nret &&
          $urandom_range(0, 7) == 0) begin
        credit_return = 1'b1;
        nret++;
      end
      tick();
    end
    gate = 1'b1;
    pkt_rdy = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (dlv_cnt >= 64 + 64 * nret) begin
        credit_return = 1'b1;
        nret++;
      end
      tick();
    end
    run(4);
    chk("rnd_src", src_q.size(), 0);
    chk("rnd_lost", exp_q.size(), 0);
    chk("rnd_cnt", dlv_cnt, acc_cnt);
    chk("rnd_cred", credits, 128 + 64 * nret - dlv_cnt);
    chk("rnd_err", err_credit_ovf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
